pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, program counter and address width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_VECTOR, default 16'h0000, first fetch address after reset.
REQ-004 SHALL have parameter NOP_WORD, default all-zero, instruction injected on flush or bubble.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port jmp_loc, input, PC_W, redirect target from the jump control stage.
REQ-008 SHALL have port pc_mux_sel, input, 1, redirect request from the jump control stage.
REQ-009 SHALL have port stall, input, 1, hazard hold from decode.
REQ-010 SHALL have port pm_data, input, INSTR_W, combinational program-memory read data for pm_addr.
REQ-011 SHALL have port pm_addr, output, PC_W, current fetch PC, driven combinationally from the PC register.
REQ-012 SHALL have port instr_out, output, INSTR_W, IF/ID instruction register.
REQ-013 SHALL have port current_address, output, PC_W, IF/ID address of instr_out, fed to the jump control stage.
REQ-014 SHALL have port instr_valid, output, 1, high when instr_out is a real fetched instruction.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, FLUSH.
REQ-016 BOOT SHALL be entered on reset, last exactly one cycle, emit a bubble, and advance PC to RESET_VECTOR+1 while capturing pm_data at RESET_VECTOR.
REQ-017 BOOT->RUN SHALL occur unconditionally unless pc_mux_sel is high, in which case BOOT->FLUSH.
REQ-018 In RUN with stall=0 and pc_mux_sel=0: PC <= PC+1; instr_out <= pm_data; current_address <= PC; instr_valid <= 1.
REQ-019 In RUN with stall=1 and pc_mux_sel=0: PC, instr_out, current_address and instr_valid SHALL hold.
REQ-020 In any state with pc_mux_sel=1: PC <= jmp_loc; instr_out <= NOP_WORD; instr_valid <= 0; current_address holds; next state FLUSH.
REQ-021 pc_mux_sel SHALL take priority over stall when both are high.
REQ-022 FLUSH SHALL last one cycle, behave as RUN for the PC update (PC <= PC+1, capture pm_data at jmp_loc), then return to RUN.
REQ-023 A pc_mux_sel during FLUSH SHALL re-redirect, with PC <= new jmp_loc, a bubble, and the FSM staying in FLUSH.
REQ-024 stall during FLUSH SHALL be ignored.
REQ-025 PC increment SHALL be modulo 2^PC_W, so 16'hFFFF+1 = 16'h0000 with no flag.
REQ-026 Redirect latency SHALL be 1: the jmp_loc instruction appears on instr_out two edges after pc_mux_sel is sampled high.

Reset
REQ-027 On reset the block SHALL set PC = RESET_VECTOR, instr_out = NOP_WORD, current_address = 0, instr_valid = 0, and state = BOOT.
REQ-028 Reset SHALL override pc_mux_sel and stall in the same cycle.
REQ-029 Reset asserted mid-FLUSH or mid-stall SHALL discard all pending state.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (BOOT=2'b00, RUN=2'b01, FLUSH=2'b10) and the PC_W, INSTR_W and NOP_WORD constants.
REQ-031 The PC register with next-PC mux SHALL be a sub-module named pc_register (inputs: load, hold, target; output: pc).
REQ-032 The IF/ID register and FSM SHALL reside in pc_fetch_unit.

Verification
REQ-033 Reset release with pm returning addr+0x100 -> cycle 1 bubble; then instr_out 0x100, 0x101, 0x102 with current_address 0, 1, 2 and instr_valid=1.
REQ-034 At PC=5, stall high for 3 cycles -> pm_addr stays 5 and instr_out/current_address are frozen for 3 cycles, then sequential fetch resumes at 6.
REQ-035 pc_mux_sel=1, jmp_loc=16'hF000 -> next edge: pm_addr=F000 and bubble; following edge: instr_out=mem[F000], current_address=F000; then F001.
REQ-036 pc_mux_sel and stall both high with jmp_loc=0x0040 -> redirect taken and pm_addr=0x0040.
REQ-037 PC at 16'hFFFF in RUN -> next pm_addr=16'h0000 and current_address=FFFF with instr_valid=1.
REQ-038 Reset asserted during FLUSH -> next cycle PC=RESET_VECTOR, instr_valid=0, state BOOT.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg
//   Shared definitions for the instruction fetch stage.
//   - pc_fetch_state_e : fetch FSM encoding (BOOT, RUN, FLUSH)
//   - FETCH_PC_W, FETCH_INSTR_W, FETCH_NOP_WORD : default widths and bubble word
package pc_fetch_unit_pkg;

  localparam int unsigned FETCH_PC_W    = 16;
  localparam int unsigned FETCH_INSTR_W = 32;
  localparam logic [FETCH_INSTR_W-1:0] FETCH_NOP_WORD = '0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } pc_fetch_state_e;

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit_pc_register.sv
// pc_register
//   Program counter with its next-PC mux.
//   Ports:
//     clk, reset : clock, synchronous active-high reset (pc <= RESET_VECTOR)
//     load       : take target as the next PC (redirect)
//     hold       : keep the current PC (stall)
//     target     : redirect address
//     pc         : current PC
//   Priority: reset > load > hold > increment. Increment wraps modulo 2^PC_W.
module pc_register #(
  parameter int unsigned      PC_W         = 16,
  parameter logic [PC_W-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            hold,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (load) begin
      pc_d = target;
    end else if (hold) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : pc_register

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Instruction fetch stage: PC, program-memory addressing and the IF/ID
//   register, sequenced by a BOOT/RUN/FLUSH FSM.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     jmp_loc         : redirect target from the jump control stage
//     pc_mux_sel      : redirect request (wins over stall)
//     stall           : decode hazard hold (honoured in RUN only)
//     pm_data         : combinational program-memory data for pm_addr
//     pm_addr         : current fetch PC
//     instr_out       : IF/ID instruction
//     current_address : IF/ID address of instr_out
//     instr_valid     : instr_out is a real fetched instruction
//     dbg_state       : FSM state, for observation only
//   No valid/ready handshake: the stage is flow-controlled by stall alone,
//   and instr_valid only qualifies instr_out (it never waits for an ack).
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned         PC_W         = FETCH_PC_W,
  parameter int unsigned         INSTR_W      = FETCH_INSTR_W,
  parameter logic [PC_W-1:0]     RESET_VECTOR = '0,
  parameter logic [INSTR_W-1:0]  NOP_WORD     = INSTR_W'(FETCH_NOP_WORD)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    jmp_loc,
  input  logic               pc_mux_sel,
  input  logic               stall,
  input  logic [INSTR_W-1:0] pm_data,
  output logic [PC_W-1:0]    pm_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    current_address,
  output logic               instr_valid,
  output logic [1:0]         dbg_state
);

  pc_fetch_state_e    state_d, state_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [PC_W-1:0]    addr_d, addr_q;
  logic               valid_d, valid_q;
  logic               pc_load;
  logic               pc_hold;
  logic [PC_W-1:0]    pc;

  pc_register #(
    .PC_W         (PC_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_register (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .hold   (pc_hold),
    .target (jmp_loc),
    .pc     (pc)
  );

  // Next-state and IF/ID update. BOOT and FLUSH both perform one normal
  // fetch (stall ignored) and then hand over to RUN; a redirect in any state
  // loads jmp_loc, injects a bubble and parks in FLUSH for one fetch.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    pc_load = 1'b0;
    pc_hold = 1'b0;

    if (pc_mux_sel) begin
      // current_address deliberately holds so the jump stage keeps its view.
      pc_load = 1'b1;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      state_d = ST_FLUSH;
    end else begin
      unique case (state_q)
        ST_BOOT, ST_FLUSH: begin
          instr_d = pm_data;
          addr_d  = pc;
          valid_d = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            pc_hold = 1'b1;
          end else begin
            instr_d = pm_data;
            addr_d  = pc;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      instr_q <= NOP_WORD;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign pm_addr         = pc;
  assign instr_out       = instr_q;
  assign current_address = addr_q;
  assign instr_valid     = valid_q;
  assign dbg_state       = state_q;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit (default parameters, RESET_VECTOR = 0).
//   Program memory returns {16'h0, addr} + 32'h100.
module tb_pc_fetch_unit;

  localparam logic [1:0] S_BOOT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel;
  logic        stall;
  logic [31:0] pm_data;
  logic [15:0] pm_addr;
  logic [31:0] instr_out;
  logic [15:0] current_address;
  logic        instr_valid;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- program memory ----------------
  assign pm_data = {16'h0000, pm_addr} + 32'h0000_0100;

  pc_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .jmp_loc         (jmp_loc),
    .pc_mux_sel      (pc_mux_sel),
    .stall           (stall),
    .pm_data         (pm_data),
    .pm_addr         (pm_addr),
    .instr_out       (instr_out),
    .current_address (current_address),
    .instr_valid     (instr_valid),
    .dbg_state       (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic sel, input logic stl,
                       input logic [15:0] jmp);
    reset      = rst;
    pc_mux_sel = sel;
    stall      = stl;
    jmp_loc    = jmp;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full IF/ID + PC snapshot against expected values.
  task automatic check_all(input string tag, input logic [15:0] e_pc,
                           input logic [31:0] e_instr, input logic [15:0] e_addr,
                           input logic e_valid, input logic [1:0] e_state);
    check({tag, ".pm_addr"}, 32'(pm_addr), 32'(e_pc));
    check({tag, ".instr"},   instr_out, e_instr);
    check({tag, ".addr"},    32'(current_address), 32'(e_addr));
    check({tag, ".valid"},   32'(instr_valid), 32'(e_valid));
    check({tag, ".state"},   32'(dbg_state), 32'(e_state));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick(); tick();
    check_all("reset", 16'h0000, 32'h0, 16'h0000, 1'b0, S_BOOT);

    // Reset overrides redirect and stall.
    drive(1'b1, 1'b1, 1'b1, 16'h1234);
    tick();
    check_all("reset_prio", 16'h0000, 32'h0, 16'h0000, 1'b0, S_BOOT);

    // Boot sequence: bubble during BOOT, then 0x100, 0x101, 0x102.
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    check("boot_bubble", 32'(instr_valid), 32'h0);
    tick(); check_all("seq0", 16'h0001, 32'h100, 16'h0000, 1'b1, S_RUN);
    tick(); check_all("seq1", 16'h0002, 32'h101, 16'h0001, 1'b1, S_RUN);
    tick(); check_all("seq2", 16'h0003, 32'h102, 16'h0002, 1'b1, S_RUN);
    tick(); tick();
    check_all("seq4", 16'h0005, 32'h104, 16'h0004, 1'b1, S_RUN);

    // Stall three cycles at PC=5.
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall", 16'h0005, 32'h104, 16'h0004, 1'b1, S_RUN);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick(); check_all("resume5", 16'h0006, 32'h105, 16'h0005, 1'b1, S_RUN);
    tick(); check_all("resume6", 16'h0007, 32'h106, 16'h0006, 1'b1, S_RUN);

    // Redirect to F000; stall during FLUSH is ignored.
    drive(1'b0, 1'b1, 1'b0, 16'hF000);
    tick(); check_all("jmp_bub", 16'hF000, 32'h0, 16'h0006, 1'b0, S_FLUSH);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    tick(); check_all("jmp_tgt", 16'hF001, 32'hF100, 16'hF000, 1'b1, S_RUN);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick(); check_all("jmp_nxt", 16'hF002, 32'hF101, 16'hF001, 1'b1, S_RUN);

    // Re-redirect while in FLUSH.
    drive(1'b0, 1'b1, 1'b0, 16'h0200);
    tick(); check_all("rr1", 16'h0200, 32'h0, 16'hF001, 1'b0, S_FLUSH);
    drive(1'b0, 1'b1, 1'b0, 16'h0300);
    tick(); check_all("rr2", 16'h0300, 32'h0, 16'hF001, 1'b0, S_FLUSH);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick(); check_all("rr_tgt", 16'h0301, 32'h400, 16'h0300, 1'b1, S_RUN);

    // Redirect and stall together: redirect wins.
    drive(1'b0, 1'b1, 1'b1, 16'h0040);
    tick(); check_all("prio", 16'h0040, 32'h0, 16'h0300, 1'b0, S_FLUSH);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick(); check_all("prio_tgt", 16'h0041, 32'h140, 16'h0040, 1'b1, S_RUN);

    // PC wrap at FFFF.
    drive(1'b0, 1'b1, 1'b0, 16'hFFFF);
    tick(); check_all("wrap_jmp", 16'hFFFF, 32'h0, 16'h0040, 1'b0, S_FLUSH);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick(); check_all("wrap_ffff", 16'h0000, 32'h100FF, 16'hFFFF, 1'b1, S_RUN);
    tick(); check_all("wrap_0000", 16'h0001, 32'h100, 16'h0000, 1'b1, S_RUN);

    // Reset during FLUSH.
    drive(1'b0, 1'b1, 1'b0, 16'h1000);
    tick(); check_all("pre_rst", 16'h1000, 32'h0, 16'h0000, 1'b0, S_FLUSH);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    tick(); check_all("rst_flush", 16'h0000, 32'h0, 16'h0000, 1'b0, S_BOOT);

    // Redirect during BOOT goes to FLUSH.
    drive(1'b0, 1'b1, 1'b0, 16'h0500);
    tick(); check_all("boot_jmp", 16'h0500, 32'h0, 16'h0000, 1'b0, S_FLUSH);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    tick(); check_all("boot_tgt", 16'h0501, 32'h600, 16'h0500, 1'b1, S_RUN);

    // Reset during stall.
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    tick(); check_all("pre_rst2", 16'h0501, 32'h600, 16'h0500, 1'b1, S_RUN);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    tick(); check_all("rst_stall", 16'h0000, 32'h0, 16'h0000, 1'b0, S_BOOT);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pc_fetch_unit
